// File: rtl/dispatcher_pkg.sv
// Shared types and helpers for the dispatcher slice.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dispatcher_pkg;

    localparam int DATA_W = 32;  // data / PC / immediate width
    localparam int ROB_W  = 4;   // ROB tag width; tag 0 means "value ready"
    localparam int OP_W   = 6;   // opcode width
    localparam int REG_W  = 5;   // architectural register index width

    // The top two opcode bits carry the instruction class.
    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_BR  = 2'b01;
    localparam logic [1:0] CLS_LD  = 2'b10;
    localparam logic [1:0] CLS_ST  = 2'b11;

    localparam logic [OP_W-1:0] OP_ADD = 6'h01;
    localparam logic [OP_W-1:0] OP_BEQ = 6'h10;
    localparam logic [OP_W-1:0] OP_LW  = 6'h20;
    localparam logic [OP_W-1:0] OP_SW  = 6'h30;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_e;

    // One source operand: either a value (id == 0) or a pending ROB tag.
    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [ROB_W-1:0]  id;
    } opnd_t;

    // A decoded instruction with resolved sources; also the hold register.
    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        opnd_t             r1;
        opnd_t             r2;
        logic [REG_W-1:0]  rd;
        logic              is_ls;
    } inst_t;

    // Registered outputs toward ROB, regfile rename port and RS/LSB.
    typedef struct packed {
        logic              rs_en;
        logic              lsb_en;
        logic              rob_en;
        logic              ren_en;
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        opnd_t             r1;
        opnd_t             r2;
        logic [ROB_W-1:0]  id;
        logic [REG_W-1:0]  rd;
    } out_t;

    function automatic logic is_ls_op(input logic [OP_W-1:0] op);
        return op[OP_W-1];
    endfunction

    // Branches and stores produce no register result.
    function automatic logic writes_rd(input logic [OP_W-1:0] op);
        return (op[OP_W-1:OP_W-2] == CLS_ALU) || (op[OP_W-1:OP_W-2] == CLS_LD);
    endfunction

    // Replace a pending tag with a broadcast value; CDB1 wins over CDB2.
    function automatic opnd_t cdb_capture(
        input opnd_t             op,
        input logic              c1_en,
        input logic [ROB_W-1:0]  c1_id,
        input logic [DATA_W-1:0] c1_dat,
        input logic              c2_en,
        input logic [ROB_W-1:0]  c2_id,
        input logic [DATA_W-1:0] c2_dat
    );
        opnd_t res;
        res = op;
        if (op.id != '0) begin
            if (c1_en && (c1_id == op.id)) begin
                res.dat = c1_dat;
                res.id  = '0;
            end else if (c2_en && (c2_id == op.id)) begin
                res.dat = c2_dat;
                res.id  = '0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dispatcher_if.sv
// Issue bus from the dispatcher to the reservation station and load/store buffer.
// Latency: n/a (wires only). Ports: full flags in, issue strobes + shared payload out.
// Backpressure: RsFull_i / LsbFull_i mean the target cannot accept next cycle.
interface dispatcher_if;
    import dispatcher_pkg::*;

    logic              RsFull_i;
    logic              LsbFull_i;
    logic              RsEn_o;
    logic              LsbEn_o;
    logic [OP_W-1:0]   IssOpcode_o;
    logic [DATA_W-1:0] IssPc_o;
    logic [DATA_W-1:0] IssImm_o;
    logic [DATA_W-1:0] IssR1Data_o;
    logic [DATA_W-1:0] IssR2Data_o;
    logic [ROB_W-1:0]  IssR1Id_o;
    logic [ROB_W-1:0]  IssR2Id_o;
    logic [ROB_W-1:0]  IssId_o;

    modport master (
        input  RsFull_i, LsbFull_i,
        output RsEn_o, LsbEn_o, IssOpcode_o, IssPc_o, IssImm_o,
               IssR1Data_o, IssR2Data_o, IssR1Id_o, IssR2Id_o, IssId_o
    );

    modport slave (
        output RsFull_i, LsbFull_i,
        input  RsEn_o, LsbEn_o, IssOpcode_o, IssPc_o, IssImm_o,
               IssR1Data_o, IssR2Data_o, IssR1Id_o, IssR2Id_o, IssId_o
    );
endinterface

// File: rtl/dispatcher_operand_resolve.sv
// Resolves one source operand: x0 -> 0, committed regfile value, ready ROB value, CDB bypass, else tag.
// Latency: combinational. Ports: register index, regfile data/tag, ROB data/ready, two CDBs in; operand out.
// Backpressure: none.
module dispatcher_operand_resolve
    import dispatcher_pkg::*;
(
    input  logic [REG_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] reg_dat_i,
    input  logic [ROB_W-1:0]  reg_id_i,
    input  logic              rob_rdy_i,
    input  logic [DATA_W-1:0] rob_dat_i,
    input  logic              cdb1_en_i,
    input  logic [ROB_W-1:0]  cdb1_id_i,
    input  logic [DATA_W-1:0] cdb1_dat_i,
    input  logic              cdb2_en_i,
    input  logic [ROB_W-1:0]  cdb2_id_i,
    input  logic [DATA_W-1:0] cdb2_dat_i,
    output opnd_t             opnd_o
);

    opnd_t pending;

    always_comb begin
        pending     = '0;
        pending.id  = reg_id_i;
        opnd_o      = '0;
        if (idx_i != '0) begin
            if (reg_id_i == '0) begin
                opnd_o.dat = reg_dat_i;
            end else if (rob_rdy_i) begin
                opnd_o.dat = rob_dat_i;
            end else begin
                // Unresolved operands carry data 0 alongside the tag.
                opnd_o = cdb_capture(pending, cdb1_en_i, cdb1_id_i, cdb1_dat_i,
                                     cdb2_en_i, cdb2_id_i, cdb2_dat_i);
            end
        end
    end

endmodule

// File: rtl/dispatcher.sv
// Dispatcher: allocates a ROB entry, resolves sources, renames rd and issues to RS or LSB.
// Latency: 1 cycle from accepted decode to issue strobes; ports: decoder, regfile, ROB, CDB x2, issue bus (iss).
// Backpressure: RS/LSB/ROB full parks the instruction in a hold register (Stall_o) that keeps snooping the CDBs.
module dispatcher
    import dispatcher_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr_i,
    input  logic              DecEn_i,
    input  logic [OP_W-1:0]   DecOpcode_i,
    input  logic [DATA_W-1:0] DecPc_i,
    input  logic [DATA_W-1:0] DecImm_i,
    input  logic [REG_W-1:0]  DecRs1_i,
    input  logic [REG_W-1:0]  DecRs2_i,
    input  logic [REG_W-1:0]  DecRd_i,
    input  logic              DecIsLS_i,
    output logic              Stall_o,
    output logic [REG_W-1:0]  RegR1Addr_o,
    output logic [REG_W-1:0]  RegR2Addr_o,
    input  logic [DATA_W-1:0] RegR1Data_i,
    input  logic [DATA_W-1:0] RegR2Data_i,
    input  logic [ROB_W-1:0]  RegR1Id_i,
    input  logic [ROB_W-1:0]  RegR2Id_i,
    output logic [ROB_W-1:0]  RobQ1Id_o,
    output logic [ROB_W-1:0]  RobQ2Id_o,
    input  logic              RobQ1Rdy_i,
    input  logic              RobQ2Rdy_i,
    input  logic [DATA_W-1:0] RobQ1Data_i,
    input  logic [DATA_W-1:0] RobQ2Data_i,
    input  logic              RobFull_i,
    input  logic [ROB_W-1:0]  RobFreeId_i,
    input  logic              cdb1En_i,
    input  logic [ROB_W-1:0]  cdb1Id_i,
    input  logic [DATA_W-1:0] cdb1Data_i,
    input  logic              cdb2En_i,
    input  logic [ROB_W-1:0]  cdb2Id_i,
    input  logic [DATA_W-1:0] cdb2Data_i,
    output logic              RobEn_o,
    output logic [OP_W-1:0]   RobOpcode_o,
    output logic [REG_W-1:0]  RobRd_o,
    output logic [DATA_W-1:0] RobPc_o,
    output logic              RegRenEn_o,
    output logic [REG_W-1:0]  RegRenAddr_o,
    output logic [ROB_W-1:0]  RegRenId_o,
    dispatcher_if.master      iss
);

    state_e state_q, state_d;
    inst_t  hold_q, hold_d;
    out_t   out_q, out_d;

    opnd_t  r1_res, r2_res;
    inst_t  dec_inst;
    inst_t  snoop_inst;
    inst_t  cand;
    logic   ok_dec, ok_hold, do_issue;

    // Regfile and ROB lookups are purely combinational from the decoder fields.
    assign RegR1Addr_o = DecRs1_i;
    assign RegR2Addr_o = DecRs2_i;
    assign RobQ1Id_o   = RegR1Id_i;
    assign RobQ2Id_o   = RegR2Id_i;

    dispatcher_operand_resolve u_res1 (
        .idx_i(DecRs1_i), .reg_dat_i(RegR1Data_i), .reg_id_i(RegR1Id_i),
        .rob_rdy_i(RobQ1Rdy_i), .rob_dat_i(RobQ1Data_i),
        .cdb1_en_i(cdb1En_i), .cdb1_id_i(cdb1Id_i), .cdb1_dat_i(cdb1Data_i),
        .cdb2_en_i(cdb2En_i), .cdb2_id_i(cdb2Id_i), .cdb2_dat_i(cdb2Data_i),
        .opnd_o(r1_res)
    );

    dispatcher_operand_resolve u_res2 (
        .idx_i(DecRs2_i), .reg_dat_i(RegR2Data_i), .reg_id_i(RegR2Id_i),
        .rob_rdy_i(RobQ2Rdy_i), .rob_dat_i(RobQ2Data_i),
        .cdb1_en_i(cdb1En_i), .cdb1_id_i(cdb1Id_i), .cdb1_dat_i(cdb1Data_i),
        .cdb2_en_i(cdb2En_i), .cdb2_id_i(cdb2Id_i), .cdb2_dat_i(cdb2Data_i),
        .opnd_o(r2_res)
    );

    always_comb begin
        dec_inst        = '0;
        dec_inst.opcode = DecOpcode_i;
        dec_inst.pc     = DecPc_i;
        dec_inst.imm    = DecImm_i;
        dec_inst.r1     = r1_res;
        dec_inst.r2     = r2_res;
        dec_inst.rd     = DecRd_i;
        dec_inst.is_ls  = DecIsLS_i;

        // Held operands after this cycle's CDB broadcasts; used both to
        // update the hold register and as bypassed data on release.
        snoop_inst    = hold_q;
        snoop_inst.r1 = cdb_capture(hold_q.r1, cdb1En_i, cdb1Id_i, cdb1Data_i,
                                    cdb2En_i, cdb2Id_i, cdb2Data_i);
        snoop_inst.r2 = cdb_capture(hold_q.r2, cdb1En_i, cdb1Id_i, cdb1Data_i,
                                    cdb2En_i, cdb2Id_i, cdb2Data_i);

        ok_dec  = !RobFull_i && (DecIsLS_i    ? !iss.LsbFull_i : !iss.RsFull_i);
        ok_hold = !RobFull_i && (hold_q.is_ls ? !iss.LsbFull_i : !iss.RsFull_i);
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        out_d        = out_q;
        out_d.rs_en  = 1'b0;
        out_d.lsb_en = 1'b0;
        out_d.rob_en = 1'b0;
        out_d.ren_en = 1'b0;
        do_issue     = 1'b0;
        cand         = dec_inst;

        case (state_q)
            ST_IDLE: begin
                if (DecEn_i) begin
                    if (ok_dec) begin
                        do_issue = 1'b1;
                    end else begin
                        hold_d  = dec_inst;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                hold_d = snoop_inst;
                cand   = snoop_inst;
                if (ok_hold) begin
                    do_issue = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_issue) begin
            out_d.rs_en  = !cand.is_ls;
            out_d.lsb_en = cand.is_ls;
            out_d.rob_en = 1'b1;
            out_d.ren_en = writes_rd(cand.opcode) && (cand.rd != '0);
            out_d.opcode = cand.opcode;
            out_d.pc     = cand.pc;
            out_d.imm    = cand.imm;
            out_d.r1     = cand.r1;
            out_d.r2     = cand.r2;
            out_d.id     = RobFreeId_i;
            out_d.rd     = writes_rd(cand.opcode) ? cand.rd : '0;
        end

        // Flush drops both the held instruction and anything presented now.
        if (clr_i) begin
            state_d = ST_IDLE;
            hold_d  = '0;
            out_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            out_q   <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
        end
    end

    assign Stall_o         = (state_q == ST_HOLD);
    assign RobEn_o         = out_q.rob_en;
    assign RobOpcode_o     = out_q.opcode;
    assign RobRd_o         = out_q.rd;
    assign RobPc_o         = out_q.pc;
    assign RegRenEn_o      = out_q.ren_en;
    assign RegRenAddr_o    = out_q.rd;
    assign RegRenId_o      = out_q.id;
    assign iss.RsEn_o      = out_q.rs_en;
    assign iss.LsbEn_o     = out_q.lsb_en;
    assign iss.IssOpcode_o = out_q.opcode;
    assign iss.IssPc_o     = out_q.pc;
    assign iss.IssImm_o    = out_q.imm;
    assign iss.IssR1Data_o = out_q.r1.dat;
    assign iss.IssR2Data_o = out_q.r2.dat;
    assign iss.IssR1Id_o   = out_q.r1.id;
    assign iss.IssR2Id_o   = out_q.r2.id;
    assign iss.IssId_o     = out_q.id;

endmodule

// File: tb/tb_dispatcher.sv
// Scoreboard bench for dispatcher: directed vectors push expected issues, a monitor pops on RsEn/LsbEn.
// Latency: issue expected one edge after acceptance or release from hold.
// Backpressure: exercised through RsFull/LsbFull, clr and rdy stalls.
module tb_dispatcher;
    import dispatcher_pkg::*;

    typedef struct packed {
        logic              rs_en;
        logic              lsb_en;
        logic              rob_en;
        logic              ren_en;
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] r1d;
        logic [ROB_W-1:0]  r1id;
        logic [DATA_W-1:0] r2d;
        logic [ROB_W-1:0]  r2id;
        logic [ROB_W-1:0]  id;
        logic [ROB_W-1:0]  ren_id;
        logic [REG_W-1:0]  rob_rd;
        logic [REG_W-1:0]  ren_addr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rdy, clr_i;
    logic DecEn_i, DecIsLS_i;
    logic [OP_W-1:0]   DecOpcode_i;
    logic [DATA_W-1:0] DecPc_i, DecImm_i;
    logic [REG_W-1:0]  DecRs1_i, DecRs2_i, DecRd_i;
    logic              Stall_o;
    logic [REG_W-1:0]  RegR1Addr_o, RegR2Addr_o;
    logic [DATA_W-1:0] RegR1Data_i, RegR2Data_i;
    logic [ROB_W-1:0]  RegR1Id_i, RegR2Id_i;
    logic [ROB_W-1:0]  RobQ1Id_o, RobQ2Id_o;
    logic              RobQ1Rdy_i, RobQ2Rdy_i;
    logic [DATA_W-1:0] RobQ1Data_i, RobQ2Data_i;
    logic              RobFull_i;
    logic [ROB_W-1:0]  RobFreeId_i;
    logic              cdb1En_i, cdb2En_i;
    logic [ROB_W-1:0]  cdb1Id_i, cdb2Id_i;
    logic [DATA_W-1:0] cdb1Data_i, cdb2Data_i;
    logic              RobEn_o;
    logic [OP_W-1:0]   RobOpcode_o;
    logic [REG_W-1:0]  RobRd_o;
    logic [DATA_W-1:0] RobPc_o;
    logic              RegRenEn_o;
    logic [REG_W-1:0]  RegRenAddr_o;
    logic [ROB_W-1:0]  RegRenId_o;

    dispatcher_if iss_if ();

    dispatcher dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr_i(clr_i),
        .DecEn_i(DecEn_i), .DecOpcode_i(DecOpcode_i), .DecPc_i(DecPc_i), .DecImm_i(DecImm_i),
        .DecRs1_i(DecRs1_i), .DecRs2_i(DecRs2_i), .DecRd_i(DecRd_i), .DecIsLS_i(DecIsLS_i),
        .Stall_o(Stall_o), .RegR1Addr_o(RegR1Addr_o), .RegR2Addr_o(RegR2Addr_o),
        .RegR1Data_i(RegR1Data_i), .RegR2Data_i(RegR2Data_i),
        .RegR1Id_i(RegR1Id_i), .RegR2Id_i(RegR2Id_i),
        .RobQ1Id_o(RobQ1Id_o), .RobQ2Id_o(RobQ2Id_o),
        .RobQ1Rdy_i(RobQ1Rdy_i), .RobQ2Rdy_i(RobQ2Rdy_i),
        .RobQ1Data_i(RobQ1Data_i), .RobQ2Data_i(RobQ2Data_i),
        .RobFull_i(RobFull_i), .RobFreeId_i(RobFreeId_i),
        .cdb1En_i(cdb1En_i), .cdb1Id_i(cdb1Id_i), .cdb1Data_i(cdb1Data_i),
        .cdb2En_i(cdb2En_i), .cdb2Id_i(cdb2Id_i), .cdb2Data_i(cdb2Data_i),
        .RobEn_o(RobEn_o), .RobOpcode_o(RobOpcode_o), .RobRd_o(RobRd_o), .RobPc_o(RobPc_o),
        .RegRenEn_o(RegRenEn_o), .RegRenAddr_o(RegRenAddr_o), .RegRenId_o(RegRenId_o),
        .iss(iss_if)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    function automatic exp_t mk(input logic ls, input logic [OP_W-1:0] op,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] r1d, input logic [3:0] r1id,
                                input logic [31:0] r2d, input logic [3:0] r2id,
                                input logic [3:0] id, input logic ren, input logic [4:0] rd);
        exp_t e;
        e.rs_en = !ls;   e.lsb_en = ls;   e.rob_en = 1'b1;  e.ren_en = ren;
        e.opcode = op;   e.pc = pc;       e.imm = imm;
        e.r1d = r1d;     e.r1id = r1id;   e.r2d = r2d;      e.r2id = r2id;
        e.id = id;       e.ren_id = id;   e.rob_rd = rd;    e.ren_addr = rd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        DecEn_i = 0; DecOpcode_i = '0; DecPc_i = '0; DecImm_i = '0;
        DecRs1_i = '0; DecRs2_i = '0; DecRd_i = '0; DecIsLS_i = 0;
        RegR1Data_i = '0; RegR2Data_i = '0; RegR1Id_i = '0; RegR2Id_i = '0;
        RobQ1Rdy_i = 0; RobQ2Rdy_i = 0; RobQ1Data_i = '0; RobQ2Data_i = '0;
        RobFull_i = 0; RobFreeId_i = 4'd1;
        iss_if.RsFull_i = 0; iss_if.LsbFull_i = 0;
        cdb1En_i = 0; cdb1Id_i = '0; cdb1Data_i = '0;
        cdb2En_i = 0; cdb2Id_i = '0; cdb2Data_i = '0;
        clr_i = 0; rdy = 1;
    endtask

    task automatic dec(input logic [OP_W-1:0] op, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic ls);
        DecEn_i = 1; DecOpcode_i = op; DecPc_i = pc; DecImm_i = imm;
        DecRs1_i = rs1; DecRs2_i = rs2; DecRd_i = rd; DecIsLS_i = ls;
    endtask

    // Monitor: every issue strobe must match the oldest expected issue.
    initial begin
        exp_t act;
        exp_t req;
        forever begin
            @(negedge clk);
            if (iss_if.RsEn_o || iss_if.LsbEn_o) begin
                act.rs_en = iss_if.RsEn_o;       act.lsb_en = iss_if.LsbEn_o;
                act.rob_en = RobEn_o;            act.ren_en = RegRenEn_o;
                act.opcode = iss_if.IssOpcode_o; act.pc = iss_if.IssPc_o;
                act.imm = iss_if.IssImm_o;
                act.r1d = iss_if.IssR1Data_o;    act.r1id = iss_if.IssR1Id_o;
                act.r2d = iss_if.IssR2Data_o;    act.r2id = iss_if.IssR2Id_o;
                act.id = iss_if.IssId_o;         act.ren_id = RegRenId_o;
                act.rob_rd = RobRd_o;            act.ren_addr = RegRenAddr_o;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected actual=%0h required=none", act);
                end else begin
                    req = exp_q.pop_front();
                    if (act !== req) begin
                        errors++;
                        $display("FAIL issue actual=%0h required=%0h", act, req);
                    end
                end
            end
        end
    end

    initial begin
        idle();
        RegR1Data_i = 32'h1234; DecEn_i = 1; DecOpcode_i = OP_ADD; DecRd_i = 5'd3;
        rst = 1;
        step(); step();
        chk("rst_stall", 64'(Stall_o), 0);
        chk("rst_rsen", 64'(iss_if.RsEn_o), 0);
        chk("rst_roben", 64'(RobEn_o), 0);
        chk("rst_r1data", 64'(iss_if.IssR1Data_o), 0);
        rst = 0;
        idle();

        // ADD x3,x1,x2 from committed regfile values.
        step();
        dec(OP_ADD, 32'h100, 32'h0, 5'd1, 5'd2, 5'd3, 0);
        RegR1Data_i = 32'd5; RegR2Data_i = 32'd7; RobFreeId_i = 4'd2;
        exp_q.push_back(mk(0, OP_ADD, 32'h100, 0, 32'd5, 0, 32'd7, 0, 4'd2, 1, 5'd3));
        #1;
        chk("rd_addr1", 64'(RegR1Addr_o), 1);
        chk("rd_addr2", 64'(RegR2Addr_o), 2);
        step(); idle();
        chk("add_roben", 64'(RobEn_o), 1);

        // rs1 via CDB2 bypass, rs2 via ready ROB entry.
        step();
        dec(OP_ADD, 32'h104, 32'h0, 5'd1, 5'd2, 5'd4, 0);
        RegR1Id_i = 4'd3; cdb2En_i = 1; cdb2Id_i = 4'd3; cdb2Data_i = 32'h10;
        RegR2Id_i = 4'd7; RobQ2Rdy_i = 1; RobQ2Data_i = 32'h77; RobFreeId_i = 4'd5;
        exp_q.push_back(mk(0, OP_ADD, 32'h104, 0, 32'h10, 0, 32'h77, 0, 4'd5, 1, 5'd4));
        #1;
        chk("rob_q1id", 64'(RobQ1Id_o), 3);
        step(); idle();

        // LW held by LsbFull for three cycles, operands captured while held.
        step();
        dec(OP_LW, 32'h200, 32'h8, 5'd1, 5'd2, 5'd6, 1);
        RegR1Id_i = 4'd4; RegR2Id_i = 4'd5; iss_if.LsbFull_i = 1; RobFreeId_i = 4'd8;
        step(); idle(); iss_if.LsbFull_i = 1;
        dec(OP_ADD, 32'h999, 32'h0, 5'd1, 5'd2, 5'd9, 0);   // must be ignored
        chk("lw_stall1", 64'(Stall_o), 1);
        step(); idle(); iss_if.LsbFull_i = 1;
        cdb1En_i = 1; cdb1Id_i = 4'd4; cdb1Data_i = 32'hAB;
        cdb2En_i = 1; cdb2Id_i = 4'd4; cdb2Data_i = 32'hEE;
        chk("lw_stall2", 64'(Stall_o), 1);
        step(); idle();
        cdb2En_i = 1; cdb2Id_i = 4'd5; cdb2Data_i = 32'hCD; RobFreeId_i = 4'd9;
        exp_q.push_back(mk(1, OP_LW, 32'h200, 32'h8, 32'hAB, 0, 32'hCD, 0, 4'd9, 1, 5'd6));
        chk("lw_stall3", 64'(Stall_o), 1);
        step(); idle();
        chk("lw_release", 64'(Stall_o), 0);

        // Flush while held, then flush an instruction presented in IDLE.
        step();
        dec(OP_ADD, 32'h280, 32'h0, 5'd1, 5'd2, 5'd7, 0);
        RegR1Data_i = 32'd1; RegR2Data_i = 32'd2; iss_if.RsFull_i = 1;
        step(); idle(); clr_i = 1;
        step(); idle();
        chk("clr_stall", 64'(Stall_o), 0);
        chk("clr_ren", 64'(RegRenEn_o), 0);
        dec(OP_ADD, 32'h284, 32'h0, 5'd1, 5'd2, 5'd7, 0); clr_i = 1;
        step(); idle();
        chk("clr_dec_roben", 64'(RobEn_o), 0);

        // rdy low during HOLD: CDB pulse is not captured.
        step();
        dec(OP_ADD, 32'h300, 32'h0, 5'd1, 5'd0, 5'd8, 0);
        RegR1Id_i = 4'hA; iss_if.RsFull_i = 1;
        step(); idle(); rdy = 0;
        cdb1En_i = 1; cdb1Id_i = 4'hA; cdb1Data_i = 32'h55;
        chk("rdy_stall", 64'(Stall_o), 1);
        step(); idle(); rdy = 0;
        step(); idle(); iss_if.RsFull_i = 1;
        chk("rdy_stall_kept", 64'(Stall_o), 1);
        step(); idle(); RobFreeId_i = 4'hB;
        exp_q.push_back(mk(0, OP_ADD, 32'h300, 0, 32'h0, 4'hA, 32'h0, 0, 4'hB, 1, 5'd8));
        step(); idle();

        // rs1 == rd: source uses the old mapping; x0 source reads as 0.
        step();
        dec(OP_ADD, 32'h400, 32'h0, 5'd5, 5'd0, 5'd5, 0);
        RegR1Id_i = 4'd6; RegR2Id_i = 4'd3; RegR2Data_i = 32'h99; RobFreeId_i = 4'hC;
        exp_q.push_back(mk(0, OP_ADD, 32'h400, 0, 32'h0, 4'd6, 32'h0, 0, 4'hC, 1, 5'd5));
        step(); idle();

        // Back-to-back BEQ (no rd), SW (to LSB), ADD x0: none renames.
        step();
        dec(OP_BEQ, 32'h500, 32'h40, 5'd1, 5'd2, 5'd9, 0);
        RegR1Data_i = 32'h11; RegR2Data_i = 32'h22; RobFreeId_i = 4'hD;
        exp_q.push_back(mk(0, OP_BEQ, 32'h500, 32'h40, 32'h11, 0, 32'h22, 0, 4'hD, 0, 5'd0));
        step(); idle();
        chk("beq_ren", 64'(RegRenEn_o), 0);
        dec(OP_SW, 32'h504, 32'h4, 5'd1, 5'd2, 5'd0, 1);
        RegR1Data_i = 32'h30; RegR2Data_i = 32'h44; RobFreeId_i = 4'hE;
        exp_q.push_back(mk(1, OP_SW, 32'h504, 32'h4, 32'h30, 0, 32'h44, 0, 4'hE, 0, 5'd0));
        step(); idle();
        chk("sw_lsben", 64'(iss_if.LsbEn_o), 1);
        dec(OP_ADD, 32'h508, 32'h0, 5'd1, 5'd2, 5'd0, 0);
        RegR1Data_i = 32'd3; RegR2Data_i = 32'd4; RobFreeId_i = 4'hF;
        exp_q.push_back(mk(0, OP_ADD, 32'h508, 0, 32'd3, 0, 32'd4, 0, 4'hF, 0, 5'd0));
        step(); idle();
        step(); step(); step();

        chk("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatcher.md
Name: dispatcher

Overview:
- Sits between the decoder and the issue queues; feeds the reservation station (ALU ops) and the load/store buffer.
- Per decoded instruction it allocates a ROB entry, resolves both source operands (regfile, ROB, CDB bypass), renames rd, and issues to RS or LSB.
- A single hold register absorbs backpressure (RS/LSB/ROB full) and keeps snooping the CDB while held.

Parameters:
DATA_W, 32, data/PC/imm width
ROB_W, 4, ROB tag width; tag 0 means "value ready"
OP_W, 6, opcode width
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global clock enable; state frozen when low
clr_i  in  1  flush (mispredict), synchronous
DecEn_i  in  1  decoder presents instruction
DecOpcode_i/DecPc_i/DecImm_i  in  OP_W/DATA_W/DATA_W  decoded fields
DecRs1_i/DecRs2_i/DecRd_i  in  REG_W each  register indices
DecIsLS_i  in  1  1 = load/store (to LSB), 0 = ALU/branch (to RS)
Stall_o  out  1  hold register occupied; decoder must not present
RegR1Addr_o/RegR2Addr_o  out  REG_W  combinational regfile read addresses
RegR1Data_i/RegR2Data_i  in  DATA_W  regfile data
RegR1Id_i/RegR2Id_i  in  ROB_W  regfile rename tag (0 = committed value)
RobQ1Id_o/RobQ2Id_o  out  ROB_W  ROB lookup tags (combinational)
RobQ1Rdy_i/RobQ2Rdy_i  in  1  ROB entry has value
RobQ1Data_i/RobQ2Data_i  in  DATA_W  ROB entry value
RobFull_i/RobFreeId_i  in  1/ROB_W  ROB status; next free tag (never 0)
RsFull_i/LsbFull_i  in  1  target cannot accept next cycle
cdb1En_i/cdb1Id_i/cdb1Data_i  in  1/ROB_W/DATA_W  CDB 1
cdb2En_i/cdb2Id_i/cdb2Data_i  in  1/ROB_W/DATA_W  CDB 2
RobEn_o/RobOpcode_o/RobRd_o/RobPc_o  out  1/OP_W/REG_W/DATA_W  ROB allocate
RegRenEn_o/RegRenAddr_o/RegRenId_o  out  1/REG_W/ROB_W  rename write
RsEn_o, LsbEn_o  out  1  issue strobes
IssOpcode_o/IssPc_o/IssImm_o/IssR1Data_o/IssR2Data_o/IssR1Id_o/IssR2Id_o/IssId_o  out  shared issue bus to RS and LSB

Behaviour:
- Reset or clr_i (when rdy high, or any time for rst): all enables 0, Stall_o 0, hold invalid; data outputs 0. clr_i drops a held instruction and any instruction presented that cycle.
- rdy low: no state change, enables hold value, no snooping.
- Operand resolution (per source, combinational, at accept): index 0 gives data 0, tag 0. Otherwise a regfile tag of 0 gives regfile data. Otherwise, if the ROB entry is ready, use the ROB data with tag 0. Otherwise a matching CDB1 gives cdb1Data, else a matching CDB2 gives cdb2Data, each with tag 0. Otherwise keep the tag; data is don't-care (drive 0).
- Sources are resolved before rename, so rs1==rd uses the old mapping.
- Resource ok = !RobFull_i && (DecIsLS_i ? !LsbFull_i : !RsFull_i).
- States IDLE (hold empty) and HOLD.
  - IDLE, DecEn_i, ok: issue at the next edge. RsEn_o or LsbEn_o = 1 for one cycle, RobEn_o = 1, IssId_o = RobFreeId_i. If DecRd_i != 0 (and the op writes rd), RegRenEn_o = 1. Latency 1 cycle. Stay IDLE.
  - IDLE, DecEn_i, !ok: latch the resolved instruction into hold; go to HOLD; Stall_o = 1 from the next cycle. No enables.
  - HOLD: each cycle, held operands with tag != 0 capture a matching CDB (CDB1 priority) and the tag becomes 0. When ok holds for the held class, issue as above using the current RobFreeId_i. A CDB match in the same cycle as issue is bypassed into the issued data. Go to IDLE; Stall_o = 0 next cycle. DecEn_i in HOLD is ignored.
- Enables are single-cycle pulses; at most one of RsEn_o/LsbEn_o per cycle.
- Back-to-back: the rename written at edge N is visible to the regfile lookup in cycle N+1 (regfile contract).
- Branch/store ops with no rd: RegRenEn_o = 0. Rd = 0: never rename.

Decomposition:
- Add to define.v: ROB tag width, opcode width, `IsLS`/`WritesRd` opcode-class macros.
- Sub-module operand_resolve (combinational): regfile/ROB/CDB priority mux; instantiate twice.
- FSM, hold register and snooping stay in dispatcher.

Test Plan:
- ADD x3,x1,x2 with both regfile tags 0 (data 5, 7), RobFreeId 2 -> next cycle RsEn_o=1, R1Data=5, R2Data=7, ids 0, IssId=2, RegRen x3->2.
- rs1 tag 3, ROB not ready, cdb2En with id 3, data 0x10 same cycle -> IssR1Data=0x10, IssR1Id=0.
- LW with LsbFull_i=1 for 3 cycles, CDB1 delivers rs1 tag 4 in cycle 2 -> Stall_o high 3 cycles; LsbEn_o on release with R1Id=0 and the CDB data; RsEn_o never asserted.
- clr_i while in HOLD -> no issue, Stall_o=0 next cycle, no rename.
- rdy low for 2 cycles during HOLD with a CDB pulse -> pulse ignored; operand stays tagged after rdy returns.
- rs1=rd=x5, x5 tag 6 -> IssR1Id=6, rename x5->new id.
